// File: rtl/wheel_pulse_gen_pkg.sv
// Shared definitions for the wheel pulse generator: default clock rate,
// taxi motion state encodings and a counter-width helper.
package wheel_pulse_gen_pkg;

    localparam int unsigned CLK_FREQ_DEFAULT = 50_000_000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STOPPED = 2'd1,
        ST_MOVING  = 2'd2
    } taxi_state_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wheel_pulse_gen_debounce.sv
// Two-flop synchroniser plus stability-count debouncer for a raw switch-like input,
// producing a clean level and a one-cycle strobe on each accepted rising edge.
module wheel_debounce
    import wheel_pulse_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 50_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic din,
    output logic dout_level,
    output logic rise_pulse
);

    localparam int unsigned    CNT_W    = cnt_width(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_ff1;
    logic             sync_out;
    logic             level_d;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_ff1 <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            sync_ff1 <= din;
            sync_out <= sync_ff1;
        end
    end

    // Any cycle where the synchronised input agrees with the accepted level restarts the count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stable_cnt <= '0;
            dout_level <= 1'b0;
        end else if (sync_out == dout_level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_LAST) begin
            stable_cnt <= '0;
            dout_level <= sync_out;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            level_d    <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            level_d    <= dout_level;
            rise_pulse <= dout_level & ~level_d;
        end
    end

endmodule

// File: rtl/wheel_pulse_gen.sv
// Converts debounced wheel rotations into 10 m distance ticks, tracks whether the
// taxi is idle, stopped or moving, and emits one-second waiting ticks while stopped.
module wheel_pulse_gen
    import wheel_pulse_gen_pkg::*;
#(
    parameter int unsigned CLK_FREQ         = CLK_FREQ_DEFAULT,
    parameter int unsigned DEBOUNCE_CYC     = 50_000,
    parameter int unsigned PULSES_PER_10M   = 4,
    parameter int unsigned STOP_TIMEOUT_CYC = 100_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic wheel_in,
    input  logic en,
    output logic ten_meter_pulse,
    output logic moving,
    output logic wait_sec_pulse
);

    localparam int unsigned DIST_W = cnt_width(PULSES_PER_10M);
    localparam int unsigned IDLE_W = cnt_width(STOP_TIMEOUT_CYC);
    localparam int unsigned SEC_W  = cnt_width(CLK_FREQ);

    localparam logic [DIST_W-1:0] DIST_LAST = DIST_W'(PULSES_PER_10M - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(STOP_TIMEOUT_CYC - 1);
    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(CLK_FREQ - 1);

    logic              wheel_level;
    logic              edge_strobe;
    logic              wheel_edge;
    logic              ten_due;
    logic              wait_pend;
    logic [DIST_W-1:0] dist_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [SEC_W-1:0]  sec_cnt;
    taxi_state_e       state;

    wheel_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .din        (wheel_in),
        .dout_level (wheel_level),
        .rise_pulse (edge_strobe)
    );

    // The strobe only ever fires while the settled level is high; gating keeps it honest.
    assign wheel_edge = edge_strobe & wheel_level;
    assign ten_due    = en & wheel_edge & (dist_cnt == DIST_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dist_cnt        <= '0;
            ten_meter_pulse <= 1'b0;
        end else if (!en) begin
            dist_cnt        <= '0;
            ten_meter_pulse <= 1'b0;
        end else if (ten_due) begin
            dist_cnt        <= '0;
            ten_meter_pulse <= 1'b1;
        end else begin
            if (wheel_edge) begin
                dist_cnt <= dist_cnt + 1'b1;
            end
            ten_meter_pulse <= 1'b0;
        end
    end

    // A second that wraps on the same edge as a completed 10 m is reported one cycle
    // later, so the downstream fare stage never sees both ticks at once.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= ST_IDLE;
            idle_cnt       <= '0;
            sec_cnt        <= '0;
            moving         <= 1'b0;
            wait_sec_pulse <= 1'b0;
            wait_pend      <= 1'b0;
        end else if (!en) begin
            state          <= ST_IDLE;
            idle_cnt       <= '0;
            sec_cnt        <= '0;
            moving         <= 1'b0;
            wait_sec_pulse <= 1'b0;
            wait_pend      <= 1'b0;
        end else begin
            wait_sec_pulse <= wait_pend;
            wait_pend      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state    <= ST_STOPPED;
                    idle_cnt <= '0;
                    sec_cnt  <= '0;
                    moving   <= 1'b0;
                end
                ST_STOPPED: begin
                    if (sec_cnt == SEC_LAST) begin
                        sec_cnt <= '0;
                        if (ten_due) begin
                            wait_pend <= 1'b1;
                        end else begin
                            wait_sec_pulse <= 1'b1;
                        end
                    end else begin
                        sec_cnt <= sec_cnt + 1'b1;
                    end
                    if (wheel_edge) begin
                        state    <= ST_MOVING;
                        idle_cnt <= '0;
                        sec_cnt  <= '0;
                        moving   <= 1'b1;
                    end
                end
                ST_MOVING: begin
                    sec_cnt <= '0;
                    if (wheel_edge) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        state    <= ST_STOPPED;
                        idle_cnt <= '0;
                        moving   <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    idle_cnt <= '0;
                    sec_cnt  <= '0;
                    moving   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wheel_pulse_gen.sv
// Directed bench for wheel_pulse_gen with small parameters: distance ticks, glitch
// rejection, enable discard, stop timeout, waiting ticks and asynchronous reset.
module tb_wheel_pulse_gen;

    localparam int unsigned CLK_FREQ         = 100;
    localparam int unsigned DEBOUNCE_CYC     = 4;
    localparam int unsigned PULSES_PER_10M   = 4;
    localparam int unsigned STOP_TIMEOUT_CYC = 50;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic wheel_in;
    logic en;
    logic ten_meter_pulse;
    logic moving;
    logic wait_sec_pulse;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int ten_cnt, ten_first, ten_last, ten_wide;
    int wait_cnt, wait_first, wait_last, wait_wide;
    int mov_rise, mov_fall, fall_cnt;
    int overlap = 0;
    logic prev_ten  = 1'b0;
    logic prev_wait = 1'b0;
    logic prev_mov  = 1'b0;
    int rise_s[8];

    wheel_pulse_gen #(
        .CLK_FREQ         (CLK_FREQ),
        .DEBOUNCE_CYC     (DEBOUNCE_CYC),
        .PULSES_PER_10M   (PULSES_PER_10M),
        .STOP_TIMEOUT_CYC (STOP_TIMEOUT_CYC)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .wheel_in        (wheel_in),
        .en              (en),
        .ten_meter_pulse (ten_meter_pulse),
        .moving          (moving),
        .wait_sec_pulse  (wait_sec_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    // Output monitor: samples 2 time units after each rising edge, cyc = edges seen so far.
    always begin
        @(posedge sys_clk);
        #2;
        cyc++;
        if (ten_meter_pulse) begin
            ten_cnt++;
            if (ten_first < 0) ten_first = cyc;
            ten_last = cyc;
            if (prev_ten) ten_wide++;
        end
        if (wait_sec_pulse) begin
            wait_cnt++;
            if (wait_first < 0) wait_first = cyc;
            wait_last = cyc;
            if (prev_wait) wait_wide++;
        end
        if (moving && !prev_mov && mov_rise < 0) mov_rise = cyc;
        if (!moving && prev_mov) begin
            fall_cnt++;
            if (mov_fall < 0) mov_fall = cyc;
        end
        if (ten_meter_pulse && wait_sec_pulse) overlap++;
        prev_ten  = ten_meter_pulse;
        prev_wait = wait_sec_pulse;
        prev_mov  = moving;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_mon();
        ten_cnt = 0;  ten_first = -1;  ten_last = -1;  ten_wide = 0;
        wait_cnt = 0; wait_first = -1; wait_last = -1; wait_wide = 0;
        mov_rise = -1; mov_fall = -1; fall_cnt = 0;
    endtask

    // Called on a falling edge; each rise is sampled by the DUT at edge cyc+1.
    task automatic run_wheel(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            wheel_in = 1'b1;
            rise_s[i] = cyc + 1;
            repeat (hi) @(negedge sys_clk);
            wheel_in = 1'b0;
            repeat (lo) @(negedge sys_clk);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b1;
        en        = 1'b0;
        wheel_in  = 1'b0;
        clear_mon();
        #3 sys_rst_n = 1'b0;
        #1;
        n_vec++;
        if (ten_meter_pulse !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_ten: got %b expected 0", ten_meter_pulse);
        end
        n_vec++;
        if (moving !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_moving: got %b expected 0", moving);
        end
        n_vec++;
        if (wait_sec_pulse !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_wait: got %b expected 0", wait_sec_pulse);
        end
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        en = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_vec++;
        if (moving !== 1'b0) begin
            n_fail++; $display("[TB] FAIL enabled_not_moving: got %b expected 0", moving);
        end
    endtask

    task automatic test_distance();
        clear_mon();
        run_wheel(8, 20, 20);
        wait_until(rise_s[7] + 60);
        n_vec++;
        if (mov_rise - rise_s[0] != 7) begin
            n_fail++; $display("[TB] FAIL moving_latency: got %0d expected 7", mov_rise - rise_s[0]);
        end
        n_vec++;
        if (ten_cnt != 2) begin
            n_fail++; $display("[TB] FAIL ten_count_8_edges: got %0d expected 2", ten_cnt);
        end
        n_vec++;
        if (ten_first - rise_s[3] != 7) begin
            n_fail++; $display("[TB] FAIL ten_latency_first: got %0d expected 7", ten_first - rise_s[3]);
        end
        n_vec++;
        if (ten_last - rise_s[7] != 7) begin
            n_fail++; $display("[TB] FAIL ten_latency_second: got %0d expected 7", ten_last - rise_s[7]);
        end
        n_vec++;
        if (ten_wide != 0) begin
            n_fail++; $display("[TB] FAIL ten_width: got %0d wide pulses expected 0", ten_wide);
        end
        n_vec++;
        if (mov_fall - rise_s[7] != 57) begin
            n_fail++; $display("[TB] FAIL stop_timeout: got %0d expected 57", mov_fall - rise_s[7]);
        end
    endtask

    task automatic test_wait_seconds();
        int base;
        base = mov_fall;
        wait_until(base + 205);
        n_vec++;
        if (wait_first - base != 100) begin
            n_fail++; $display("[TB] FAIL wait_first_delay: got %0d expected 100", wait_first - base);
        end
        n_vec++;
        if (wait_cnt != 2) begin
            n_fail++; $display("[TB] FAIL wait_count: got %0d expected 2", wait_cnt);
        end
        n_vec++;
        if (wait_last - wait_first != 100) begin
            n_fail++; $display("[TB] FAIL wait_period: got %0d expected 100", wait_last - wait_first);
        end
        n_vec++;
        if (wait_wide != 0) begin
            n_fail++; $display("[TB] FAIL wait_width: got %0d wide pulses expected 0", wait_wide);
        end
        n_vec++;
        if (moving !== 1'b0) begin
            n_fail++; $display("[TB] FAIL stopped_moving: got %b expected 0", moving);
        end
    endtask

    task automatic test_glitch();
        int s;
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            wheel_in = 1'b1;
            repeat (DEBOUNCE_CYC - 1) @(negedge sys_clk);
            wheel_in = 1'b0;
            repeat (5) @(negedge sys_clk);
        end
        repeat (10) @(negedge sys_clk);
        n_vec++;
        if (ten_cnt != 0) begin
            n_fail++; $display("[TB] FAIL glitch_ten: got %0d expected 0", ten_cnt);
        end
        n_vec++;
        if (mov_rise != -1) begin
            n_fail++; $display("[TB] FAIL glitch_moved: moving rose at cycle %0d expected never", mov_rise);
        end
        n_vec++;
        if (moving !== 1'b0) begin
            n_fail++; $display("[TB] FAIL glitch_state: got moving %b expected 0", moving);
        end
        s = cyc + 1;
        wheel_in = 1'b1;
        repeat (DEBOUNCE_CYC) @(negedge sys_clk);
        wheel_in = 1'b0;
        wait_until(s + 10);
        n_vec++;
        if (mov_rise - s != 7) begin
            n_fail++; $display("[TB] FAIL min_width_accept: got %0d expected 7", mov_rise - s);
        end
    endtask

    task automatic test_en_discard();
        int s;
        en = 1'b0;
        repeat (2) @(negedge sys_clk);
        n_vec++;
        if (moving !== 1'b0) begin
            n_fail++; $display("[TB] FAIL en_low_moving: got %b expected 0", moving);
        end
        en = 1'b1;
        repeat (2) @(negedge sys_clk);
        clear_mon();
        run_wheel(3, 20, 20);
        s = cyc + 1;
        wheel_in = 1'b1;
        repeat (7) @(negedge sys_clk);
        en = 1'b0;
        @(negedge sys_clk);
        n_vec++;
        if (moving !== 1'b0) begin
            n_fail++; $display("[TB] FAIL en_priority: got moving %b expected 0 at cycle %0d", moving, cyc - s);
        end
        repeat (12) @(negedge sys_clk);
        wheel_in = 1'b0;
        repeat (20) @(negedge sys_clk);
        en = 1'b1;
        repeat (3) @(negedge sys_clk);
        run_wheel(1, 20, 20);
        repeat (10) @(negedge sys_clk);
        n_vec++;
        if (ten_cnt != 0) begin
            n_fail++; $display("[TB] FAIL partial_discard: got %0d pulses expected 0", ten_cnt);
        end
        clear_mon();
        run_wheel(3, 20, 20);
        repeat (10) @(negedge sys_clk);
        n_vec++;
        if (ten_cnt != 1) begin
            n_fail++; $display("[TB] FAIL reenable_count: got %0d expected 1", ten_cnt);
        end
        n_vec++;
        if (ten_first - rise_s[2] != 7) begin
            n_fail++; $display("[TB] FAIL reenable_latency: got %0d expected 7", ten_first - rise_s[2]);
        end
    endtask

    task automatic test_timeout_boundary();
        en = 1'b0;
        repeat (2) @(negedge sys_clk);
        en = 1'b1;
        repeat (2) @(negedge sys_clk);
        run_wheel(1, 20, 30);
        clear_mon();
        run_wheel(4, 20, 30);
        n_vec++;
        if (fall_cnt != 0) begin
            n_fail++; $display("[TB] FAIL edge_at_timeout_fall: got %0d falls expected 0", fall_cnt);
        end
        n_vec++;
        if (moving !== 1'b1) begin
            n_fail++; $display("[TB] FAIL edge_at_timeout_moving: got %b expected 1", moving);
        end
        n_vec++;
        if (wait_cnt != 0) begin
            n_fail++; $display("[TB] FAIL edge_at_timeout_wait: got %0d expected 0", wait_cnt);
        end
        wait_until(rise_s[3] + 56);
        n_vec++;
        if (moving !== 1'b1) begin
            n_fail++; $display("[TB] FAIL pre_timeout_moving: got %b expected 1", moving);
        end
        @(negedge sys_clk);
        n_vec++;
        if (moving !== 1'b0) begin
            n_fail++; $display("[TB] FAIL post_timeout_moving: got %b expected 0", moving);
        end
    endtask

    task automatic test_reset_midrun();
        int s;
        en = 1'b0;
        repeat (2) @(negedge sys_clk);
        en = 1'b1;
        repeat (2) @(negedge sys_clk);
        clear_mon();
        run_wheel(3, 20, 20);
        s = cyc + 1;
        wheel_in = 1'b1;
        repeat (6) @(negedge sys_clk);
        wheel_in = 1'b0;
        repeat (2) @(negedge sys_clk);
        n_vec++;
        if (ten_meter_pulse !== 1'b1) begin
            n_fail++; $display("[TB] FAIL pre_reset_ten: got %b expected 1", ten_meter_pulse);
        end
        n_vec++;
        if (moving !== 1'b1) begin
            n_fail++; $display("[TB] FAIL pre_reset_moving: got %b expected 1", moving);
        end
        sys_rst_n = 1'b0;
        #1;
        n_vec++;
        if (ten_meter_pulse !== 1'b0) begin
            n_fail++; $display("[TB] FAIL async_reset_ten: got %b expected 0", ten_meter_pulse);
        end
        n_vec++;
        if (moving !== 1'b0) begin
            n_fail++; $display("[TB] FAIL async_reset_moving: got %b expected 0", moving);
        end
        n_vec++;
        if (wait_sec_pulse !== 1'b0) begin
            n_fail++; $display("[TB] FAIL async_reset_wait: got %b expected 0", wait_sec_pulse);
        end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        clear_mon();
        run_wheel(2, 20, 20);
        n_vec++;
        if (moving !== 1'b1) begin
            n_fail++; $display("[TB] FAIL midrun_moving: got %b expected 1", moving);
        end
        sys_rst_n = 1'b0;
        #1;
        n_vec++;
        if (moving !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midrun_reset_moving: got %b expected 0", moving);
        end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        clear_mon();
        run_wheel(3, 20, 20);
        n_vec++;
        if (ten_cnt != 0) begin
            n_fail++; $display("[TB] FAIL post_reset_partial: got %0d expected 0", ten_cnt);
        end
        run_wheel(1, 20, 20);
        n_vec++;
        if (ten_cnt != 1) begin
            n_fail++; $display("[TB] FAIL post_reset_count: got %0d expected 1", ten_cnt);
        end
        n_vec++;
        if (ten_first - rise_s[0] != 7) begin
            n_fail++; $display("[TB] FAIL post_reset_latency: got %0d expected 7", ten_first - rise_s[0]);
        end
    endtask

    initial begin
        $display("[TB] starting wheel_pulse_gen bench");
        test_reset();
        test_distance();
        test_wait_seconds();
        test_glitch();
        test_en_discard();
        test_timeout_boundary();
        test_reset_midrun();
        n_vec++;
        if (overlap != 0) begin
            n_fail++; $display("[TB] FAIL tick_overlap: got %0d cycles with both ticks expected 0", overlap);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
